// File: rtl/cga_composite_seq.sv
// Character-clock strobes, vsync-deferred B/W mode update and CRTC sync watchdog for the CGA composite encoder.
// Input edges are detected from a registered stage and outputs are registered, so an input edge at cycle n shows at n+2.
module cga_composite_seq #(
  parameter int   HCLK_DIV   = 16,
  parameter int   LCLK_RATIO = 2,
  parameter logic BW_RESET   = 1'b1,
  parameter int   HS_TIMEOUT = 4096,
  parameter int   VS_TIMEOUT = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync_l,
  input  logic       mode_wr,
  input  logic       mode_bw,
  output logic       hclk,
  output logic       lclk,
  output logic       bw_mode,
  output logic       mode_pending,
  output logic       sync_lost,
  output logic [7:0] frame_cnt
);

  localparam int DIV_W = $clog2(HCLK_DIV);
  localparam int HR_W  = (LCLK_RATIO > 1) ? $clog2(LCLK_RATIO) : 1;
  localparam int HS_W  = $clog2(HS_TIMEOUT + 1);
  localparam int VS_W  = $clog2(VS_TIMEOUT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HCLK_DIV / 2);
  localparam logic [HR_W-1:0]  HR_LAST  = HR_W'(LCLK_RATIO - 1);
  localparam logic [HS_W-1:0]  HS_MAX   = HS_W'(HS_TIMEOUT);
  localparam logic [VS_W-1:0]  VS_MAX   = VS_W'(VS_TIMEOUT);

  typedef enum logic {IDLE, PEND} state_t;

  logic             hs_cur_q, hs_prev_q, vs_cur_q, vs_prev_q;
  logic             hs_rise, vs_fall;
  logic [DIV_W-1:0] div_q;
  logic [HR_W-1:0]  hr_q;
  logic             hclk_q, lclk_q;
  state_t           state_q;
  logic             pend_val_q, bw_q, pend_q;
  logic [7:0]       frame_q;
  logic [HS_W-1:0]  hs_cnt_q, hs_cnt_d;
  logic [VS_W-1:0]  vs_cnt_q, vs_cnt_d;
  logic             lost_q, lost_d;

  assign hs_rise = hs_cur_q & ~hs_prev_q;
  assign vs_fall = vs_prev_q & ~vs_cur_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_cur_q  <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_cur_q  <= 1'b1;
      vs_prev_q <= 1'b1;
      div_q     <= '0;
      hr_q      <= '0;
      hclk_q    <= 1'b0;
      lclk_q    <= 1'b0;
    end else begin
      hs_cur_q  <= hsync;
      hs_prev_q <= hs_cur_q;
      vs_cur_q  <= vsync_l;
      vs_prev_q <= vs_cur_q;
      div_q     <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      hclk_q    <= (div_q < DIV_HALF);
      // div==0 is the clk on which hclk goes high; lclk rides on every LCLK_RATIO-th one.
      lclk_q    <= (div_q == '0) && (hr_q == '0);
      if (div_q == '0)
        hr_q <= (hr_q == HR_LAST) ? '0 : hr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_val_q <= 1'b0;
      bw_q       <= BW_RESET;
      pend_q     <= 1'b0;
      frame_q    <= 8'd0;
    end else begin
      if (vs_fall)
        frame_q <= frame_q + 8'd1;
      case (state_q)
        IDLE: begin
          if (mode_wr) begin
            pend_val_q <= mode_bw;
            state_q    <= PEND;
            pend_q     <= 1'b1;
          end
        end
        PEND: begin
          if (mode_wr)
            pend_val_q <= mode_bw;
          // A write landing on the vsync edge waits a full frame; the older value goes out now.
          if (vs_fall) begin
            bw_q    <= pend_val_q;
            state_q <= mode_wr ? PEND : IDLE;
            pend_q  <= mode_wr;
          end
        end
        default: begin
          state_q <= IDLE;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    hs_cnt_d = hs_cnt_q;
    if (hs_rise)
      hs_cnt_d = '0;
    else if (hs_cnt_q < HS_MAX)
      hs_cnt_d = hs_cnt_q + 1'b1;

    vs_cnt_d = vs_cnt_q;
    if (vs_fall)
      vs_cnt_d = '0;
    else if (hs_rise && (vs_cnt_q < VS_MAX))
      vs_cnt_d = vs_cnt_q + 1'b1;

    lost_d = lost_q;
    if (vs_fall && (hs_cnt_q < HS_MAX))
      lost_d = 1'b0;
    else if ((hs_cnt_q == HS_MAX) || (vs_cnt_q == VS_MAX))
      lost_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_cnt_q <= '0;
      vs_cnt_q <= '0;
      lost_q   <= 1'b0;
    end else begin
      hs_cnt_q <= hs_cnt_d;
      vs_cnt_q <= vs_cnt_d;
      lost_q   <= lost_d;
    end
  end

  assign hclk         = hclk_q;
  assign lclk         = lclk_q;
  assign bw_mode      = bw_q;
  assign mode_pending = pend_q;
  assign sync_lost    = lost_q;
  assign frame_cnt    = frame_q;

endmodule

// File: tb/tb_cga_composite_seq.sv
// Scoreboard bench for cga_composite_seq: stimulus queues expected outputs, monitors pop and compare on negedge.
module tb_cga_composite_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync = 1'b0;
  logic       vsync_l = 1'b1;
  logic       mode_wr = 1'b0;
  logic       mode_bw = 1'b0;
  logic       hclk, lclk, bw_mode, mode_pending, sync_lost;
  logic [7:0] frame_cnt;

  cga_composite_seq #(
    .HCLK_DIV(16), .LCLK_RATIO(2), .BW_RESET(1'b1), .HS_TIMEOUT(4096), .VS_TIMEOUT(512)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync_l(vsync_l),
    .mode_wr(mode_wr), .mode_bw(mode_bw), .hclk(hclk), .lclk(lclk),
    .bw_mode(bw_mode), .mode_pending(mode_pending), .sync_lost(sync_lost),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       chk_clk;
    logic       h;
    logic       l;
    logic       bw;
    logic       pend;
    logic       lost;
    logic [7:0] f;
  } exp_t;

  typedef struct {
    int kind;  // 0 hclk rise, 1 hclk fall, 2 lclk pulse
    int rel;
  } edge_t;

  exp_t  exp_q[$];
  edge_t edge_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    chk_n = 0;
  int    cyc = 0;
  int    t0 = 0;
  logic  clk_mon_en = 1'b0;
  logic  hclk_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk_n = 0;
    end
  endtask

  task automatic expect_out(input string tag, input logic chk_clk, input logic h, input logic l,
                            input logic bw, input logic pend, input logic lost, input logic [7:0] f);
    exp_t e;
    e.tag = tag; e.chk_clk = chk_clk; e.h = h; e.l = l;
    e.bw = bw; e.pend = pend; e.lost = lost; e.f = f;
    exp_q.push_back(e);
    chk_n++;
  endtask

  task automatic check_edge(input int kind, input int rel);
    edge_t e;
    n_tests++;
    if (edge_q.size() == 0) begin
      n_fail++;
      $display("FAIL clk_edge: got kind=%0d at rel=%0d, required no further edge", kind, rel);
    end else begin
      e = edge_q.pop_front();
      if (e.kind != kind || e.rel != rel) begin
        n_fail++;
        $display("FAIL clk_edge: got kind=%0d at rel=%0d, required kind=%0d at rel=%0d",
                 kind, rel, e.kind, e.rel);
      end
    end
  endtask

  // Output monitor: pops one expectation per pending check request.
  always @(negedge clk) begin
    exp_t e;
    logic [12:0] got, req;
    for (int i = 0; i < chk_n; i++) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: check requested with empty expectation queue");
      end else begin
        e = exp_q.pop_front();
        got = {e.chk_clk ? hclk : 1'b0, e.chk_clk ? lclk : 1'b0, bw_mode, mode_pending, sync_lost, frame_cnt};
        req = {e.chk_clk ? e.h : 1'b0, e.chk_clk ? e.l : 1'b0, e.bw, e.pend, e.lost, e.f};
        if (got !== req) begin
          n_fail++;
          $display("FAIL %s: got hclk=%b lclk=%b bw=%b pend=%b lost=%b frame=%0d, required hclk=%b lclk=%b bw=%b pend=%b lost=%b frame=%0d",
                   e.tag, got[12], got[11], got[10], got[9], got[8], got[7:0],
                   req[12], req[11], req[10], req[9], req[8], req[7:0]);
        end
      end
    end
  end

  // Strobe monitor: every hclk transition and every lclk-high clk is an event to match.
  always @(negedge clk) begin
    if (clk_mon_en) begin
      if (hclk !== hclk_prev)
        check_edge(hclk ? 0 : 1, cyc - t0);
      if (lclk === 1'b1)
        check_edge(2, cyc - t0);
      hclk_prev = hclk;
    end
  end

  task automatic wr(input logic v);
    mode_wr = 1'b1;
    mode_bw = v;
    step(1);
    mode_wr = 1'b0;
  endtask

  task automatic hs_pulse();
    hsync = 1'b1;
    step(1);
    hsync = 1'b0;
    step(1);
  endtask

  // The registered vsync edge is seen during the second clk; do_wr lands on that clk.
  task automatic vs_pulse(input logic do_wr, input logic v);
    vsync_l = 1'b0;
    step(1);
    vsync_l = 1'b1;
    mode_wr = do_wr;
    mode_bw = v;
    step(1);
    mode_wr = 1'b0;
  endtask

  initial begin
    edge_t ev;
    int    exp_rel[10];
    int    exp_kind[10];

    step(3);
    expect_out("reset_state", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

    exp_kind = '{0, 2, 1, 0, 1, 0, 2, 1, 0, 1};
    exp_rel  = '{1, 1, 9, 17, 25, 33, 33, 41, 49, 57};
    for (int i = 0; i < 10; i++) begin
      ev.kind = exp_kind[i];
      ev.rel = exp_rel[i];
      edge_q.push_back(ev);
    end
    reset = 1'b0;
    t0 = cyc;
    hclk_prev = 1'b0;
    clk_mon_en = 1'b1;
    step(64);
    clk_mon_en = 1'b0;
    n_tests++;
    if (edge_q.size() != 0) begin
      n_fail++;
      $display("FAIL clk_edges_missing: got %0d unseen edges, required 0", edge_q.size());
    end

    // Deferred write of 0 over BW_RESET=1.
    wr(1'b0);
    expect_out("wr0_pending", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    step(3);
    expect_out("wr0_midframe_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    vsync_l = 1'b0;
    step(1);
    expect_out("vs_edge_plus1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    vsync_l = 1'b1;
    step(1);
    expect_out("vs_edge_plus2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    // Last write in a frame wins.
    wr(1'b0);
    step(2);
    wr(1'b1);
    expect_out("last_write_pending", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    vs_pulse(1'b0, 1'b0);
    expect_out("last_write_applied", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);

    // Write on the vsync edge: old value applied, new one held a frame.
    wr(1'b0);
    step(2);
    vs_pulse(1'b1, 1'b1);
    expect_out("coincident_old_applied", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
    step(2);
    vs_pulse(1'b0, 1'b0);
    expect_out("coincident_next_frame", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);

    // Writing the current value still goes through PEND.
    wr(1'b1);
    expect_out("same_value_pending", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4);
    vs_pulse(1'b0, 1'b0);
    expect_out("same_value_applied", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5);

    // hsync watchdog boundary and saturation.
    hs_pulse();
    step(4096);
    expect_out("hs_timeout_minus1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
    step(1);
    expect_out("hs_timeout_set", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5);
    step(4200);
    vs_pulse(1'b0, 1'b0);
    expect_out("hs_saturated_no_clear", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd6);
    hs_pulse();
    expect_out("hs_resume_still_lost", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd6);
    vs_pulse(1'b0, 1'b0);
    expect_out("hs_resume_cleared", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7);

    // vsync watchdog: 512 hsyncs with vsync_l stuck high.
    for (int i = 0; i < 512; i++) hs_pulse();
    expect_out("vs_timeout_minus1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7);
    step(1);
    expect_out("vs_timeout_set", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd7);
    vs_pulse(1'b0, 1'b0);
    expect_out("vs_clear_priority", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8);

    // frame_cnt wrap.
    for (int i = 0; i < 247; i++) vs_pulse(1'b0, 1'b0);
    expect_out("frame_255", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd255);
    vs_pulse(1'b0, 1'b0);
    expect_out("frame_wrap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

    // Reset with a pending write and sync_lost set.
    hs_pulse();
    step(4097);
    wr(1'b0);
    expect_out("pre_reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
    reset = 1'b1;
    step(1);
    expect_out("mid_reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    vs_pulse(1'b0, 1'b0);
    expect_out("pending_discarded", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    step(2);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cga_composite_seq.md
Name: cga_composite_seq

Overview:
Sequencer and configuration controller for the CGA composite encoder.
- Derives the character-clock strobes hclk and lclk from the 28.636 MHz master clock.
- Applies writes to the B/W-mode bit at vsync only, so the colour burst never switches mid-frame.
- Watches the CRTC sync inputs and raises a sync-lost status.
- Sits between the CRTC/mode register and the composite encoder; all in the single clk domain.

Parameters:
HCLK_DIV, 16, clk cycles per hclk period (80-column character clock); must be even, >=4
LCLK_RATIO, 2, hclk periods per lclk pulse (40-column character clock)
BW_RESET, 1, value of bw_mode after reset
HS_TIMEOUT, 4096, clk cycles without an hsync rising edge before sync_lost is set
VS_TIMEOUT, 512, hsync rising edges without a vsync_l falling edge before sync_lost is set

Ports:
clk  in  1  master clock, 28.636 MHz
reset  in  1  synchronous, active-high reset
hsync  in  1  CRTC hsync, active high, clk domain
vsync_l  in  1  CRTC vsync, active low, clk domain
mode_wr  in  1  one-cycle write strobe from the mode register
mode_bw  in  1  B/W bit written with mode_wr
hclk  out  1  square wave, period HCLK_DIV clk cycles, high for the first half
lclk  out  1  one-clk pulse on every LCLK_RATIO-th hclk rising edge
bw_mode  out  1  B/W mode presented to the encoder
mode_pending  out  1  a written mode value awaits vsync
sync_lost  out  1  sync watchdog flag
frame_cnt  out  8  vsync counter, wraps at 255 -> 0

Behaviour:
- Reset values: hclk=0, lclk=0, bw_mode=BW_RESET, mode_pending=0, sync_lost=0, frame_cnt=0.
- Reset clears all counters and edge-detect registers (previous-hsync=0, previous-vsync_l=1). Reset mid-operation discards any pending write.
- Divider counter div: 0..HCLK_DIV-1 with wrap; hclk=1 while div<HCLK_DIV/2 (registered).
  - First hclk rising edge occurs on the first clk after reset deasserts (div 0 -> hclk=1).
- hclk-rise counter hr: 0..LCLK_RATIO-1. lclk=1 for exactly one clk, coincident with the first clk of hclk high when hr==0.
  - After reset, the first lclk is coincident with the first hclk high.
- Mode handshake uses a two-state FSM:
  - IDLE: mode_wr -> store mode_bw in pend_val; go to PEND; mode_pending=1 from the next clk.
  - PEND: a further mode_wr overwrites pend_val (last write wins) and stays in PEND.
  - PEND: on a vsync_l falling edge (registered prev=1, cur=0), bw_mode<=pend_val and go to IDLE (mode_pending=0) on the same edge.
  - A mode_wr on the same clk as the vsync edge: the new value is captured and the FSM stays or returns to PEND. The old pend_val is applied, and the new value waits for the next frame.
  - Writing a value equal to the current bw_mode still goes through PEND (no shortcut).
- frame_cnt increments by 1 on every vsync_l falling edge (8-bit wrap).
- Watchdog counters:
  - hs_cnt counts clk and clears on every hsync rising edge. It saturates at HS_TIMEOUT; reaching HS_TIMEOUT sets sync_lost.
  - vs_cnt counts hsync rising edges and clears on every vsync_l falling edge. It saturates at VS_TIMEOUT; reaching VS_TIMEOUT sets sync_lost.
  - sync_lost clears only on a vsync_l falling edge that occurs while hs_cnt<HS_TIMEOUT. That clear takes priority over a set in the same clk.
  - Counters must not wrap; saturation width is ceil(log2(timeout+1)).
- Latency: edge detection costs 1 clk. Outputs are registered, so an input edge at cycle n is reflected at n+2.

Test Plan:
- Release reset, free run 64 clk -> hclk period 16 (8 high/8 low); lclk pulses at clk 1, 33 (every 32 clk), each one cycle wide and aligned to hclk rising edges.
- BW_RESET=1; mode_wr with mode_bw=0 mid-frame -> mode_pending=1 next clk, bw_mode stays 1; at vsync_l fall bw_mode=0 and mode_pending=0 two clk after the edge.
- Writes 0 then 1 within one frame -> only 1 applied at vsync; write coincident with vsync edge -> old value applied, mode_pending stays 1, new value applied at the next vsync.
- Hold hsync low 4096 clk -> sync_lost=1; resume normal hsync/vsync -> sync_lost=0 after the first vsync_l fall; hs_cnt never wraps.
- 512 hsyncs with vsync_l stuck high -> sync_lost=1; frame_cnt unchanged; 256 vsyncs -> frame_cnt wraps to 0.
- Assert reset while mode_pending=1 and sync_lost=1 -> all outputs at reset values next clk; pending value never applied.
